ecc_host_driver: RTL
====================

# ecc_host_driver

Host-side initiator for the ECC scalar-multiplication core (`a`, `prime`, `Px`, `Py`, `k` in; `kPx`, `kPy`, `done` out; `start` pulse).
- Accepts one job at a time on a valid/ready request port.
- Drives the core's operands and start strobe, waits for the core's completion.
- Captures the result point and returns it on a valid/ready response port.
- Sits between the on-chip test/control logic and the ECC core instance.

## Interface
Parameters:
- `W`, 4: operand/result width, matching the core.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before abort (used only with the timeout feature).

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request accepted when valid & ready.
- `i_req_a`, `i_req_prime`, `i_req_px`, `i_req_py`, `i_req_k`  in  W each  job operands.
- `o_core_start`  out  1  one-cycle start strobe to the core.
- `o_core_a`, `o_core_prime`, `o_core_px`, `o_core_py`, `o_core_k`  out  W each  registered operands to the core.
- `o_core_rst`  out  1  active-high abort reset to the core.
- `i_core_kpx`, `i_core_kpy`  in  W each  core result.
- `i_core_done`  in  1  core completion (level or pulse).
- `o_rsp_valid`  out  1  response valid.
- `i_rsp_ready`  in  1  response consumed when valid & ready.
- `o_rsp_kpx`, `o_rsp_kpy`  out  W each  captured result.
- `o_rsp_timeout`  out  1  job aborted.
- `o_busy`  out  1  FSM not in IDLE.
- `o_job_cnt`  out  8  completed-response count, wraps 255→0.

## Operation
FSM states are IDLE, START, WAIT, RESP.
- **IDLE:** `o_req_ready`=1. On valid & ready, register all five operands and go to START.
- **START:** `o_core_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:** detect a rising edge of `i_core_done` (`done & ~done_q`, with `done_q` registered every cycle).
  - On an edge: capture `i_core_kpx`/`i_core_kpy`, set `o_rsp_timeout`=0, go to RESP.
  - A `done` already high on entry to WAIT (stale from the previous job) is ignored until it falls and rises again.
- **RESP:** `o_rsp_valid`=1 with data stable. On `i_rsp_ready`, increment `o_job_cnt` and go to IDLE.
- **Operand hold:** `o_core_*` operands stay stable from START until the next request is accepted.
- **No overlap:** request and response handshakes never happen in the same cycle. A new request is taken only in IDLE.
- **Reset values:** all outputs 0, except `o_req_ready`, which is 1 in IDLE once reset deasserts. During reset `o_req_ready`=0.
- **Reset mid-operation:** abandon the job, FSM returns to IDLE, no response is issued, `o_job_cnt` is cleared.

## Timing
- Request accepted at cycle N → `o_core_start`=1 at N+1.
- Earliest response: `done` edge sampled at cycle M in WAIT → `o_rsp_valid`=1 at M+1.
- Minimum job turnaround is 4 cycles (accept, START, WAIT with `done` at first WAIT cycle, RESP with immediate ready).
- `o_rsp_valid` stays high until it is consumed. Response data does not change while valid.
- `o_busy` equals (state != IDLE), registered-state based.

## Configuration
- `ECC_DRV_TIMEOUT_EN` defined:
  - An 8-bit counter increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `done` edge: assert `o_core_rst` for 2 cycles, set response kpx=kpy=0 and `o_rsp_timeout`=1, go to RESP.
  - `o_rsp_timeout` is cleared on the next accepted request.
- Undefined: no counter is built. WAIT waits indefinitely, and `o_core_rst` and `o_rsp_timeout` are tied 0.

## Structure
- **Shared package `ecc_pkg`:**
  - state enum (IDLE/START/WAIT/RESP)
  - default `ECC_W`=4
  - `ECC_TIMEOUT_DEF`=255
  - the operand struct {a, prime, px, py, k}
- **Sub-module `ecc_edge_det`:** rising-edge detector on `i_core_done`, with synchronous active-low reset. Everything else is a single FSM module.

## Test plan
- **Basic doubling:** request a=1, prime=11, P=(2,7), k=2; behavioural core raises `done` 10 cycles after start with (5,2) → single `o_core_start` pulse; response kpx=5, kpy=2, timeout=0; `o_job_cnt`=1.
- **Stale done:** hold `i_core_done`=1 across the job boundary, then drop it and raise it after 6 cycles → the first response appears only after the new rising edge.
- **Back-pressure:** hold `i_rsp_ready`=0 for 20 cycles → `o_rsp_valid`, kpx and kpy stay constant; `o_req_ready`=0 throughout; on release the FSM returns to IDLE in 1 cycle.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** core never asserts `done` → `o_core_rst` high for 2 cycles after 16 WAIT cycles; response timeout=1, kpx=kpy=0.
- **Reset mid-WAIT:** assert `i_rst_n`=0 for 1 cycle → all outputs return to reset values; no response; `o_job_cnt`=0; the next job completes normally.
- **Counter wrap:** 256 back-to-back jobs → `o_job_cnt` wraps to 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg -- shared definitions for the ECC host driver slice.
//   ECC_W            default operand/result width of the ECC core
//   ECC_TIMEOUT_DEF  default WAIT-cycle limit before a job is aborted
//   ecc_state_t      driver FSM states
//   ecc_ops_t        one job's operand set {a, prime, px, py, k}
package ecc_pkg;

  localparam int ECC_W           = 4;
  localparam int ECC_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ecc_state_t;

  typedef struct packed {
    logic [ECC_W-1:0] a;
    logic [ECC_W-1:0] prime;
    logic [ECC_W-1:0] px;
    logic [ECC_W-1:0] py;
    logic [ECC_W-1:0] k;
  } ecc_ops_t;

endpackage

// File: rtl/ecc_edge_det.sv
// ecc_edge_det -- rising-edge detector for the core's done signal.
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (clears the delayed copy)
//   i_sig    level to watch
//   o_rise   high in the cycle where i_sig is 1 and was 0 the cycle before
// The delayed copy is updated every cycle regardless of the driver state, so a
// level that is already high when the driver starts waiting never looks like
// a fresh edge.
module ecc_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic sig_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/ecc_host_driver.sv
// ecc_host_driver -- host-side initiator for the ECC scalar-multiplication core.
// Takes one job on the request port, registers the operands, pulses the core's
// start, waits for a rising edge of the core's done, captures the result point
// and offers it on the response port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. Request: o_req_ready is high only in IDLE (and never while reset
// is asserted). Response: o_rsp_valid stays high with stable data until
// i_rsp_ready is seen; the two ports never transfer in the same cycle.
//
// Build option: define ECC_DRV_TIMEOUT_EN to add the WAIT timeout (counter,
// 2-cycle o_core_rst abort pulse, o_rsp_timeout flag). Without it WAIT waits
// forever and o_core_rst / o_rsp_timeout are tied 0.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req_valid / o_req_ready      request handshake
//   i_req_a .. i_req_k             job operands
//   o_core_start                   one-cycle start strobe to the core
//   o_core_a .. o_core_k           registered operands, held until next accept
//   o_core_rst                     active-high abort reset to the core
//   i_core_kpx, i_core_kpy         core result
//   i_core_done                    core completion (level or pulse)
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_kpx, o_rsp_kpy           captured result
//   o_rsp_timeout                  job was aborted
//   o_busy                         FSM not in IDLE
//   o_job_cnt                      completed-response count (wraps)
//   o_dbg_state                    current FSM state for observation
module ecc_host_driver
  import ecc_pkg::*;
#(
  parameter int W              = ECC_W,
  parameter int TIMEOUT_CYCLES = ECC_TIMEOUT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [W-1:0] i_req_a,
  input  logic [W-1:0] i_req_prime,
  input  logic [W-1:0] i_req_px,
  input  logic [W-1:0] i_req_py,
  input  logic [W-1:0] i_req_k,
  output logic         o_core_start,
  output logic [W-1:0] o_core_a,
  output logic [W-1:0] o_core_prime,
  output logic [W-1:0] o_core_px,
  output logic [W-1:0] o_core_py,
  output logic [W-1:0] o_core_k,
  output logic         o_core_rst,
  input  logic [W-1:0] i_core_kpx,
  input  logic [W-1:0] i_core_kpy,
  input  logic         i_core_done,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_kpx,
  output logic [W-1:0] o_rsp_kpy,
  output logic         o_rsp_timeout,
  output logic         o_busy,
  output logic [7:0]   o_job_cnt,
  output ecc_state_t   o_dbg_state
);

  ecc_state_t state, state_next;
  logic       done_rise;
  logic       timeout_hit;
  logic       accept;
  logic       capture;

  ecc_edge_det u_done_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_core_done),
    .o_rise  (done_rise)
  );

  assign accept  = (state == ST_IDLE) && i_req_valid;
  // An edge takes priority over a timeout landing in the same cycle.
  assign capture = (state == ST_WAIT) && done_rise;

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_next   = state;
    o_req_ready  = 1'b0;
    o_core_start = 1'b0;
    o_rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated with reset so nothing is offered while reset is held.
        o_req_ready = i_rst_n;
        if (i_req_valid) state_next = ST_START;
      end
      ST_START: begin
        o_core_start = 1'b1;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise || timeout_hit) state_next = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      o_core_a     <= '0;
      o_core_prime <= '0;
      o_core_px    <= '0;
      o_core_py    <= '0;
      o_core_k     <= '0;
      o_rsp_kpx    <= '0;
      o_rsp_kpy    <= '0;
      o_job_cnt    <= 8'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        o_core_a     <= i_req_a;
        o_core_prime <= i_req_prime;
        o_core_px    <= i_req_px;
        o_core_py    <= i_req_py;
        o_core_k     <= i_req_k;
      end
      if (capture) begin
        o_rsp_kpx <= i_core_kpx;
        o_rsp_kpy <= i_core_kpy;
      end else if (timeout_hit) begin
        o_rsp_kpx <= '0;
        o_rsp_kpy <= '0;
      end
      if ((state == ST_RESP) && i_rsp_ready) begin
        o_job_cnt <= o_job_cnt + 8'd1;
      end
    end
  end

`ifdef ECC_DRV_TIMEOUT_EN
  // wait_cnt counts completed WAIT cycles; the abort fires in the WAIT cycle
  // that would bring it to TIMEOUT_CYCLES.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic [1:0] core_rst_cnt;
  logic       rsp_timeout_q;

  assign timeout_hit = (state == ST_WAIT) && !done_rise && (wait_cnt == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt      <= 8'd0;
      core_rst_cnt  <= 2'd0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wait_cnt <= 8'd0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Two-cycle abort pulse starting the cycle after the timeout.
      if (timeout_hit) begin
        core_rst_cnt <= 2'd2;
      end else if (core_rst_cnt != 2'd0) begin
        core_rst_cnt <= core_rst_cnt - 2'd1;
      end

      if (accept || capture) begin
        rsp_timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign o_core_rst    = (core_rst_cnt != 2'd0);
  assign o_rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign o_core_rst    = 1'b0;
  assign o_rsp_timeout = 1'b0;
`endif

  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;

endmodule
